uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, meaning data bits per frame; legal range 5..8.
REQ-002 SHALL have parameter SB_TICK, default 16, meaning rx_tick pulses per stop bit; legal values 16, 24 or 32.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx_tick, input, 1 bit: one-clk pulse at 16x baud, from the baud rate generator's rx_tick output.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port rd, input, 1 bit: read acknowledge; clears rx_ready.
REQ-008 SHALL have port dout, output, DBIT bits: last received data word.
REQ-009 SHALL have port rx_ready, output, 1 bit: dout holds an unread word.
REQ-010 SHALL have port frame_err, output, 1 bit: one-clk pulse when the stop bit is sampled low.
REQ-011 SHALL have port overrun_err, output, 1 bit: sticky; a word completed while rx_ready was high.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (preset to 1); all logic uses the synchronized value rx_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, with a 4-bit tick counter s and a 3-bit bit counter n.
REQ-014 IDLE: with armed=1 and rx_s=0 -> START, s=0; armed sets whenever rx_s=1 in IDLE and clears on leaving IDLE.
REQ-015 START: on each rx_tick s++; at rx_tick with s=7, rx_s=0 -> DATA with s=0, n=0; rx_s=1 -> IDLE (glitch, nothing reported).
REQ-016 DATA: on each rx_tick s++; at rx_tick with s=15, shift rx_s into the MSB of shift register b (LSB-first line order), s=0; n=DBIT-1 -> STOP, else n++.
REQ-017 STOP: on each rx_tick s++; at rx_tick with s=SB_TICK-1 (count wraps modulo-16 for SB_TICK>16), sample rx_s and go to IDLE.
REQ-018 Stop sample 1: dout<=b, rx_ready<=1 on the next clk; stop sample 0: frame_err pulses 1 clk, dout and rx_ready unchanged.
REQ-019 Counters SHALL advance only on clk edges where rx_tick=1; clocks without a tick hold all state.
REQ-020 rd=1 SHALL clear rx_ready on the next clk edge; rd while rx_ready=0 has no effect.
REQ-021 Word completes while rx_ready=1 and rd=0: overwrite dout, keep rx_ready=1, set overrun_err.
REQ-022 Word completes in the same cycle as rd=1: dout updates, rx_ready stays 1, overrun_err not set.
REQ-023 overrun_err SHALL clear on the first rd=1.
REQ-024 After a frame error, a new start requires rx_s=1 for at least one clk first (no break retrigger).

Reset
REQ-025 On reset: state IDLE, s=0, n=0, b=0, dout=0, rx_ready=0, frame_err=0, overrun_err=0, armed=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no frame_err/rx_ready pulse; reception resumes from IDLE after deassertion.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state typedef and the constants OVERSAMPLE=16 and MID_TICK=7.
REQ-028 Synchronizer SHALL be sub-module uart_sync2 (clk, reset, d, q; reset value 1); FSM and datapath stay in uart_rx.

Verification
REQ-029 Frame 0xA5 (line bits 1,0,1,0,0,1,0,1 LSB-first), 16 ticks/bit -> dout=0xA5, rx_ready=1, frame_err=0.
REQ-030 Frame 0x3C with stop bit driven 0 -> frame_err one-clk pulse, dout unchanged, rx_ready=0; next valid 0x3C is accepted only after the line returns high.
REQ-031 rx low for 4 ticks, then high -> FSM back to IDLE, no rx_ready, no frame_err.
REQ-032 Frames 0x00 then 0xFF with no rd -> dout=0xFF, rx_ready=1, overrun_err=1; rd pulse -> rx_ready=0, overrun_err=0.
REQ-033 rd asserted on the same clk that 0x55 completes (rx_ready already 1) -> dout=0x55, rx_ready=1, overrun_err=0.
REQ-034 reset pulse during data bit 3 of 0x81 -> all outputs 0; following frame 0x81 -> dout=0x81, rx_ready=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; both flops preset to the idle level (1).
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop framing with ready, frame-error and overrun flags.
//
// state | meaning
// IDLE  | line idle; waits for a falling edge once the line has been seen high (armed)
// START | counting to mid start bit; a high sample there is treated as a glitch
// DATA  | sampling DBIT data bits mid-bit, LSB first
// STOP  | counting to the stop sample; high completes the word, low is a frame error
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_tick,
    input  logic            rx,
    input  logic            rd,
    output logic [DBIT-1:0] dout,
    output logic            rx_ready,
    output logic            frame_err,
    output logic            overrun_err
);

    // The 4-bit tick counter wraps during long stop bits; wrap_q counts the wraps
    // so the terminal compare still lands on tick SB_TICK-1.
    localparam int STOP_LAST  = SB_TICK - 1;
    localparam int STOP_WRAPS = STOP_LAST / OVERSAMPLE;
    localparam int STOP_S     = STOP_LAST % OVERSAMPLE;

    logic            rx_s;

    uart_state_e     state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [1:0]      wrap_q, wrap_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            armed_q, armed_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            ready_q, ready_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;

    logic            stop_done;
    logic            word_done;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            wrap_q  <= '0;
            b_q     <= '0;
            armed_q <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            wrap_q  <= wrap_d;
            b_q     <= b_d;
            armed_q <= armed_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic: framing FSM with tick-gated counters.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        wrap_d    = wrap_q;
        b_d       = b_q;
        armed_d   = armed_q;
        stop_done = 1'b0;
        case (state_q)
            IDLE: begin
                // Leaving IDLE always disarms, so a held-low break cannot retrigger.
                if (armed_q && !rx_s) begin
                    state_d = START;
                    s_d     = '0;
                    armed_d = 1'b0;
                end else if (rx_s) begin
                    armed_d = 1'b1;
                end
            end
            START: begin
                if (rx_tick) begin
                    if (s_q == 4'(MID_TICK)) begin
                        s_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (rx_tick) begin
                    if (s_q == 4'(OVERSAMPLE - 1)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == 3'(DBIT - 1)) begin
                            state_d = STOP;
                            wrap_d  = '0;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (rx_tick) begin
                    if (s_q == 4'(STOP_S) && wrap_q == 2'(STOP_WRAPS)) begin
                        stop_done = 1'b1;
                        state_d   = IDLE;
                        s_d       = '0;
                    end else begin
                        s_d = s_q + 4'd1;
                        if (s_q == 4'(OVERSAMPLE - 1)) begin
                            wrap_d = wrap_q + 2'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign word_done = stop_done && rx_s;

    // Output flags: word completion wins over a same-cycle read; overrun is sticky until read.
    always_comb begin
        dout_d  = dout_q;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        ferr_d  = stop_done && !rx_s;
        if (word_done) begin
            dout_d  = b_q;
            ready_d = 1'b1;
        end else if (rd) begin
            ready_d = 1'b0;
        end
        if (rd) begin
            ovr_d = 1'b0;
        end else if (word_done && ready_q) begin
            ovr_d = 1'b1;
        end
    end

    assign dout        = dout_q;
    assign rx_ready    = ready_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: table of frames plus hand-written corner sequences.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_tick;
    logic       rx;
    logic       rd;
    logic [7:0] dout;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;

    int checks   = 0;
    int errors   = 0;
    int ferr_cnt = 0;

    typedef struct {
        logic       pre_rd;
        logic [7:0] data;
        logic       stop_bit;
        logic       rd_last;
        logic [7:0] exp_dout;
        logic       exp_ready;
        int         exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[7];

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_tick     (rx_tick),
        .rx          (rx),
        .rd          (rd),
        .dout        (dout),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    // Each high cycle of frame_err is counted once, so a one-clk pulse adds exactly 1.
    always @(negedge clk) if (frame_err) ferr_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // One tick every 3 clocks; rx changes two clocks before the tick so the synchronizer has settled.
    task automatic tick(input logic with_rd);
        repeat (2) @(negedge clk);
        rx_tick = 1'b1;
        rd      = with_rd;
        @(negedge clk);
        rx_tick = 1'b0;
        rd      = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic rd_pulse();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    // Start bit + 8 data bits, 16 ticks each. The stop sample falls on the 9th tick of the
    // stop bit (the first start tick is spent leaving IDLE), where rd_last is applied.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input logic rd_last);
        rx = 1'b0;
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            ticks(16);
        end
        rx = stop_val;
        ticks(8);
        tick(rd_last);
        ticks(7);
        rx = 1'b1;
        ticks(4);
    endtask

    initial begin
        int f0;

        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 0, 1'b0};
        vecs[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1, 1'b0};
        vecs[2] = '{1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 0, 1'b0};
        vecs[3] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0};
        vecs[4] = '{1'b0, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 1'b1};
        vecs[5] = '{1'b1, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 0, 1'b0};
        vecs[6] = '{1'b0, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 0, 1'b0};

        reset   = 1'b1;
        rx      = 1'b1;
        rx_tick = 1'b0;
        rd      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dout", dout, 0);
        check("reset_ready", rx_ready, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun_err, 0);
        reset = 1'b0;
        ticks(2);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].pre_rd) begin
                rd_pulse();
                check($sformatf("v%0d_rd_ready", v), rx_ready, 0);
                check($sformatf("v%0d_rd_ovr", v), overrun_err, 0);
            end
            f0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].rd_last);
            check($sformatf("v%0d_dout", v), dout, vecs[v].exp_dout);
            check($sformatf("v%0d_ready", v), rx_ready, vecs[v].exp_ready);
            check($sformatf("v%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("v%0d_ovr", v), overrun_err, vecs[v].exp_ovr);
        end

        // Frame error followed by a long break: no retrigger until the line returns high.
        rd_pulse();
        f0 = ferr_cnt;
        rx = 1'b0;
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = (i == 2 || i == 3 || i == 4 || i == 5) ? 1'b1 : 1'b0;
            ticks(16);
        end
        rx = 1'b0;
        ticks(200);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_ready", rx_ready, 0);
        check("break_dout", dout, 8'h55);
        rx = 1'b1;
        ticks(4);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("after_break_dout", dout, 8'h3C);
        check("after_break_ready", rx_ready, 1);
        check("after_break_ferr", ferr_cnt - f0, 1);

        // Start-bit glitch: low for 4 ticks only.
        rd_pulse();
        f0 = ferr_cnt;
        rx = 1'b0;
        ticks(4);
        rx = 1'b1;
        ticks(12);
        check("glitch_ready", rx_ready, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_dout", dout, 8'h3C);
        send_frame(8'hC3, 1'b1, 1'b0);
        check("after_glitch_dout", dout, 8'hC3);
        check("after_glitch_ready", rx_ready, 1);

        // Reset in the middle of data bit 3 of 0x81.
        f0 = ferr_cnt;
        rx = 1'b0;
        ticks(16);
        rx = 1'b1;
        ticks(16);
        rx = 1'b0;
        ticks(16);
        ticks(16);
        ticks(8);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_dout", dout, 0);
        check("midrst_ready", rx_ready, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_ovr", overrun_err, 0);
        reset = 1'b0;
        rx    = 1'b1;
        ticks(4);
        check("midrst_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        check("after_rst_dout", dout, 8'h81);
        check("after_rst_ready", rx_ready, 1);
        check("after_rst_ovr", overrun_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
